// File: rtl/dot_energy_pkg.sv
// Purpose: shared types, widths and constants for the dot-energy accumulator slice.
// Ports:   none (package).
// Notes:   energy_width() derives the result width so a full frame of worst-case terms cannot wrap.
package dot_energy_pkg;

  // Result width: dot width + growth for N terms + 1 bit so that negating the
  // most-negative dot (-2^(DOT_WIDTH-1)) is representable.
  function automatic int energy_width(input int dot_w, input int n);
    return dot_w + $clog2(n) + 1;
  endfunction

  localparam int DEFAULT_DOT_WIDTH    = 13;
  localparam int DEFAULT_VECTOR_SIZE  = 256;
  localparam int DEFAULT_ENERGY_WIDTH = energy_width(DEFAULT_DOT_WIDTH, DEFAULT_VECTOR_SIZE);

  typedef logic signed [DEFAULT_ENERGY_WIDTH-1:0] energy_t;

  // Most-positive energy: reset value of the running minimum.
  localparam energy_t ENERGY_MAX = {1'b0, {(DEFAULT_ENERGY_WIDTH-1){1'b1}}};

  // Frame position; fully implied by the column counter.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_LAST  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/dot_energy_accumulator_if.sv
// Purpose: beat-in / energy-out handshake bundle for the dot-energy accumulator.
// Ports:   in_valid/in_ready/in_dot/in_sigma (column beats), out_valid/out_ready/out_energy (frame result).
// Modports: master = controller side, slave = accumulator side.
interface dot_energy_accumulator_if
  import dot_energy_pkg::*;
#(
  parameter int DOT_WIDTH   = DEFAULT_DOT_WIDTH,
  parameter int VECTOR_SIZE = DEFAULT_VECTOR_SIZE
);
  localparam int ENERGY_WIDTH = energy_width(DOT_WIDTH, VECTOR_SIZE);

  logic                           in_valid;
  logic                           in_ready;
  logic [DOT_WIDTH-1:0]           in_dot;
  logic                           in_sigma;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [ENERGY_WIDTH-1:0] out_energy;

  modport master (
    output in_valid, in_dot, in_sigma, out_ready,
    input  in_ready, out_valid, out_energy
  );

  modport slave (
    input  in_valid, in_dot, in_sigma, out_ready,
    output in_ready, out_valid, out_energy
  );
endinterface

// File: rtl/dot_energy_min_tracker.sv
// Purpose: keeps the lowest frame energy seen since reset and flags each strict improvement.
// Ports:   clk, rst, done_i (frame completes this cycle), energy_i (that frame's Q),
//          best_energy_o (running minimum), best_update_o (1-cycle pulse, aligned with out_valid).
module dot_energy_min_tracker #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                done_i,
  input  logic signed [W-1:0] energy_i,
  output logic signed [W-1:0] best_energy_o,
  output logic                best_update_o
);
  // Most-positive W-bit value, so the first completed frame always wins.
  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

  logic signed [W-1:0] best_q, best_d;
  logic                upd_q, upd_d;

  always_comb begin
    best_d = best_q;
    upd_d  = 1'b0;
    // Strict compare: ties keep the earlier frame and do not pulse.
    if (done_i && (energy_i < best_q)) begin
      best_d = energy_i;
      upd_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q <= MAX_VAL;
      upd_q  <= 1'b0;
    end else begin
      best_q <= best_d;
      upd_q  <= upd_d;
    end
  end

  assign best_energy_o = best_q;
  assign best_update_o = upd_q;
endmodule

// File: rtl/dot_energy_accumulator.sv
// Purpose: sums +/-h_i over VECTOR_SIZE column beats and presents the frame energy Q in a registered slot.
// Ports:   clk, rst (sync, active-high), bus (slave: beats in, energy out), col_idx (next expected column);
//          with DOT_ENERGY_MIN_TRACK_EN defined also best_energy / best_update (running minimum of Q).
// Timing:  out_valid 1 cycle after the last beat; in_ready = ~out_valid | out_ready, back-to-back frames bubble-free.
module dot_energy_accumulator
  import dot_energy_pkg::*;
#(
  parameter  int VECTOR_SIZE  = DEFAULT_VECTOR_SIZE,
  parameter  int DOT_WIDTH    = DEFAULT_DOT_WIDTH,
  localparam int ENERGY_WIDTH = energy_width(DOT_WIDTH, VECTOR_SIZE),
  localparam int IDX_W        = $clog2(VECTOR_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  dot_energy_accumulator_if.slave bus,
  output logic [IDX_W-1:0]        col_idx
`ifdef DOT_ENERGY_MIN_TRACK_EN
  ,
  output logic signed [ENERGY_WIDTH-1:0] best_energy,
  output logic                           best_update
`endif
);

  logic signed [ENERGY_WIDTH-1:0] acc_q, acc_d;
  logic signed [ENERGY_WIDTH-1:0] energy_q, energy_d;
  logic                           out_valid_q, out_valid_d;
  logic [IDX_W-1:0]               col_q, col_d;

  logic signed [ENERGY_WIDTH-1:0] dot_ext, term, sum;
  logic                           in_ready, accept;
  acc_state_e                     state;

  // Widen before negating so -2^(DOT_WIDTH-1) flips to a positive value.
  assign dot_ext = {{(ENERGY_WIDTH-DOT_WIDTH){bus.in_dot[DOT_WIDTH-1]}}, bus.in_dot};
  assign term    = bus.in_sigma ? dot_ext : -dot_ext;
  assign sum     = acc_q + term;

  // Output slot frees up in the same cycle it is consumed.
  assign in_ready = ~out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;
  assign state    = (col_q == IDX_W'(VECTOR_SIZE - 1)) ? ST_LAST : ST_ACCUM;

  always_comb begin
    acc_d       = acc_q;
    col_d       = col_q;
    energy_d    = energy_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Register updates are gated by accept, so junk on in_dot while idle never lands in state.
    if (accept) begin
      case (state)
        ST_ACCUM: begin
          acc_d = sum;
          col_d = col_q + IDX_W'(1);
        end
        ST_LAST: begin
          // A last beat landing with the slot drain overrides the clear above.
          energy_d    = sum;
          out_valid_d = 1'b1;
          acc_d       = '0;
          col_d       = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      col_q       <= '0;
      energy_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      col_q       <= col_d;
      energy_q    <= energy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_energy = energy_q;
  assign col_idx        = col_q;

`ifdef DOT_ENERGY_MIN_TRACK_EN
  logic last_accept;
  assign last_accept = accept && (state == ST_LAST);

  dot_energy_min_tracker #(
    .W (ENERGY_WIDTH)
  ) u_min_tracker (
    .clk           (clk),
    .rst           (rst),
    .done_i        (last_accept),
    .energy_i      (sum),
    .best_energy_o (best_energy),
    .best_update_o (best_update)
  );
`endif

endmodule

// File: tb/tb_dot_energy_accumulator.sv
module tb_dot_energy_accumulator;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int EW = 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] col_idx;

  dot_energy_accumulator_if #(.DOT_WIDTH(DW), .VECTOR_SIZE(N)) bus ();

`ifdef DOT_ENERGY_MIN_TRACK_EN
  logic signed [EW-1:0] best_energy;
  logic                 best_update;
`endif

  dot_energy_accumulator #(
    .VECTOR_SIZE (N),
    .DOT_WIDTH   (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .col_idx (col_idx)
`ifdef DOT_ENERGY_MIN_TRACK_EN
    ,
    .best_energy (best_energy),
    .best_update (best_update)
`endif
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  int  stalls = 0;
  int  bupd_cnt = 0;
  bit  chk_en = 1'b0;
  bit  rand_mode = 1'b0;
  int  obs[$];

  // Reference model: frame = list of signed terms; Q = plain integer sum once N are collected.
  bit  m_valid;
  int  m_energy;
  int  m_best;
  bit  m_bupd;
  int  beats[$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_valid  = 1'b0;
      m_energy = 0;
      m_best   = (1 << (EW - 1)) - 1;
      m_bupd   = 1'b0;
      beats.delete();
    end else begin
      bit rdy;
      int q;
      int d;
      rdy    = !m_valid || bus.out_ready;
      m_bupd = 1'b0;
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (bus.in_valid && rdy) begin
        d = int'($signed(bus.in_dot));
        beats.push_back(bus.in_sigma ? d : -d);
        if (beats.size() == N) begin
          q = 0;
          foreach (beats[i]) q += beats[i];
          m_energy = q;
          m_valid  = 1'b1;
          beats.delete();
          if (q < m_best) begin
            m_best = q;
            m_bupd = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", int'(bus.in_ready), int'(!m_valid || bus.out_ready));
      check("out_valid", int'(bus.out_valid), int'(m_valid));
      check("out_energy", int'($signed(bus.out_energy)), m_energy);
      check("col_idx", int'(col_idx), beats.size());
`ifdef DOT_ENERGY_MIN_TRACK_EN
      check("best_energy", int'($signed(best_energy)), m_best);
      check("best_update", int'(best_update), int'(m_bupd));
      if (best_update) bupd_cnt++;
`endif
      if (bus.out_valid && bus.out_ready && !rst)
        obs.push_back(int'($signed(bus.out_energy)));
    end
  end

  // All driver tasks enter and leave 1 time unit after a rising edge.
  task automatic beat(input int d, input bit s);
    int  n;
    bit  rdy;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_dot   = DW'(d);
    bus.in_sigma = s;
    forever begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      stalls++;
      if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
      n++;
      if (n > 200) begin
        total++;
        bad++;
        $display("FAIL beat_wait: in_ready stuck low, got 0 required 1 at %0t", $time);
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic frame(input int d0, input int d1, input int d2, input int d3,
                       input bit s0, input bit s1, input bit s2, input bit s3);
    beat(d0, s0);
    beat(d1, s1);
    beat(d2, s2);
    beat(d3, s3);
  endtask

  task automatic expect_obs(input string name, input int exp);
    int n;
    n = 0;
    while (obs.size() == 0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (obs.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no energy handshake seen, required %0d", name, exp);
    end else begin
      check(name, obs.pop_front(), exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.in_valid  = 1'b0;
    bus.in_dot    = '0;
    bus.in_sigma  = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_col_idx", int'(col_idx), 0);
    check("rst_out_energy", int'($signed(bus.out_energy)), 0);
    @(posedge clk);
    #1;

    // 1: basic frame, 1-cycle latency
    frame(3, -2, 5, 1, 1, 0, 1, 0);
    @(negedge clk);
    check("t1_latency_valid", int'(bus.out_valid), 1);
    check("t1_energy_lit", int'($signed(bus.out_energy)), 9);
    @(posedge clk);
    #1;
    expect_obs("t1_energy", 9);

    // 2: back-to-back, no bubble
    stalls = 0;
    frame(1, 1, 1, 1, 1, 1, 1, 1);
    frame(2, 2, 2, 2, 0, 0, 0, 0);
    check("t2_no_bubble", stalls, 0);
    expect_obs("t2_frame_a", 4);
    expect_obs("t2_frame_b", -8);

    // 3: most-negative dot negates without overflow
    frame(-128, -128, -128, -128, 0, 0, 0, 0);
    expect_obs("t3_neg_min", 512);
    frame(-128, -128, -128, -128, 1, 1, 1, 1);
    expect_obs("t3_pos_min", -512);

    // 4: output backpressure freezes the input side
    bus.out_ready = 1'b0;
    frame(1, 1, 1, 1, 1, 1, 1, 1);
    bus.in_valid = 1'b1;
    bus.in_dot   = DW'(3);
    bus.in_sigma = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_in_ready_low", int'(bus.in_ready), 0);
    end
    check("t4_col_frozen", int'(col_idx), 0);
    check("t4_energy_held", int'($signed(bus.out_energy)), 4);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    frame(3, -2, 5, 1, 1, 0, 1, 0);
    expect_obs("t4_frame_a", 4);
    expect_obs("t4_frame_b", 9);

    // 5: reset mid-frame discards the partial sum
    obs.delete();
    beat(100, 1);
    beat(-50, 0);
    pulse_reset();
    @(negedge clk);
    check("t5_out_valid", int'(bus.out_valid), 0);
    check("t5_col_idx", int'(col_idx), 0);
    @(posedge clk);
    #1;
    frame(3, -2, 5, 1, 1, 0, 1, 0);
    expect_obs("t5_energy", 9);

`ifdef DOT_ENERGY_MIN_TRACK_EN
    // 6: running minimum, strict improvement only
    pulse_reset();
    obs.delete();
    base = bupd_cnt;
    frame(3, -2, 5, 1, 1, 0, 1, 0);
    frame(1, 1, 1, 1, 0, 0, 0, 0);
    frame(1, 2, 3, 1, 1, 1, 1, 1);
    frame(1, 1, 1, 1, 0, 0, 0, 0);
    idle(3);
    check("t6_best_energy", int'($signed(best_energy)), -4);
    check("t6_update_pulses", bupd_cnt - base, 2);
    obs.delete();
`endif

    // Randomized frames with input gaps and output stalls
    rand_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int b = 0; b < N; b++) begin
        idle($urandom_range(0, 2));
        beat(int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)));
      end
    end
    rand_mode = 1'b0;
    bus.out_ready = 1'b1;
    idle(5);
    base = obs.size();
    check("rand_frames_out", base, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
